// File: rtl/ofdm_pkg.sv
// Shared constants and types for the OFDM transform blocks.
package ofdm_pkg;

  localparam int unsigned IW  = 8;
  localparam int unsigned OW  = 11;
  localparam int unsigned TWW = 8;

  // sqrt(2)/2 in Q0.7 and the half-LSB added before the >>> 7
  localparam int TW_DIAG  = 91;
  localparam int RND_HALF = 64;

  localparam int SAT_MAX = (2 ** (OW - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (OW - 1));

  localparam int unsigned BITREV [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  typedef enum logic [1:0] {
    tw_w0 = 2'd0,
    tw_pj = 2'd1,
    tw_dp = 2'd2,
    tw_dm = 2'd3
  } tw_sel_e;

  function automatic tw_sel_e stage3_tw(input int unsigned k);
    case (k)
      0:       return tw_w0;
      1:       return tw_dp;
      2:       return tw_pj;
      default: return tw_dm;
    endcase
  endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational complex radix-2 butterfly: y0 = a + w*b, y1 = a - w*b.
module ifft_bfly #(
  parameter int unsigned W   = 8,
  parameter int unsigned OWB = 9,
  parameter int unsigned TWW = 8
) (
  input  logic signed [W-1:0]   a_re,
  input  logic signed [W-1:0]   a_im,
  input  logic signed [W-1:0]   b_re,
  input  logic signed [W-1:0]   b_im,
  input  ofdm_pkg::tw_sel_e     sel,
  output logic signed [OWB-1:0] y0_re,
  output logic signed [OWB-1:0] y0_im,
  output logic signed [OWB-1:0] y1_re,
  output logic signed [OWB-1:0] y1_im
);

  localparam int unsigned XW = W + 2;
  localparam int unsigned PW = XW + TWW + 1;

  logic signed [XW-1:0] ar, ai, br, bi, s, d, mr, mi, tr, ti;
  logic signed [PW-1:0] pr, pi;

  always_comb begin
    ar = XW'(a_re);
    ai = XW'(a_im);
    br = XW'(b_re);
    bi = XW'(b_im);
    s  = br + bi;
    d  = br - bi;
    // (1+j)/sqrt2 -> (d, s); (-1+j)/sqrt2 -> (-s, d); both exact before scaling
    if (sel == ofdm_pkg::tw_dm) begin
      mr = -s;
      mi = d;
    end else begin
      mr = d;
      mi = s;
    end
    pr = (PW'(mr) * PW'(ofdm_pkg::TW_DIAG) + PW'(ofdm_pkg::RND_HALF)) >>> (TWW - 1);
    pi = (PW'(mi) * PW'(ofdm_pkg::TW_DIAG) + PW'(ofdm_pkg::RND_HALF)) >>> (TWW - 1);
    case (sel)
      ofdm_pkg::tw_w0: begin
        tr = br;
        ti = bi;
      end
      ofdm_pkg::tw_pj: begin
        tr = -bi;
        ti = br;
      end
      default: begin
        tr = XW'(pr);
        ti = XW'(pi);
      end
    endcase
    y0_re = OWB'(ar + tr);
    y0_im = OWB'(ai + ti);
    y1_re = OWB'(ar - tr);
    y1_im = OWB'(ai - ti);
  end

endmodule

// File: rtl/ifft_8.sv
// Eight-point pipelined radix-2 DIT inverse FFT, unscaled, saturated output with overflow flag.
module ifft_8
  import ofdm_pkg::tw_sel_e;
  import ofdm_pkg::stage3_tw;
#(
  parameter int unsigned IW  = ofdm_pkg::IW,
  parameter int unsigned OW  = ofdm_pkg::OW,
  parameter int unsigned TWW = ofdm_pkg::TWW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 i_valid,
  input  logic signed [IW-1:0] i_re0,
  input  logic signed [IW-1:0] i_re1,
  input  logic signed [IW-1:0] i_re2,
  input  logic signed [IW-1:0] i_re3,
  input  logic signed [IW-1:0] i_re4,
  input  logic signed [IW-1:0] i_re5,
  input  logic signed [IW-1:0] i_re6,
  input  logic signed [IW-1:0] i_re7,
  input  logic signed [IW-1:0] i_im0,
  input  logic signed [IW-1:0] i_im1,
  input  logic signed [IW-1:0] i_im2,
  input  logic signed [IW-1:0] i_im3,
  input  logic signed [IW-1:0] i_im4,
  input  logic signed [IW-1:0] i_im5,
  input  logic signed [IW-1:0] i_im6,
  input  logic signed [IW-1:0] i_im7,
  output logic                 o_valid,
  output logic signed [OW-1:0] o_re0,
  output logic signed [OW-1:0] o_re1,
  output logic signed [OW-1:0] o_re2,
  output logic signed [OW-1:0] o_re3,
  output logic signed [OW-1:0] o_re4,
  output logic signed [OW-1:0] o_re5,
  output logic signed [OW-1:0] o_re6,
  output logic signed [OW-1:0] o_re7,
  output logic signed [OW-1:0] o_im0,
  output logic signed [OW-1:0] o_im1,
  output logic signed [OW-1:0] o_im2,
  output logic signed [OW-1:0] o_im3,
  output logic signed [OW-1:0] o_im4,
  output logic signed [OW-1:0] o_im5,
  output logic signed [OW-1:0] o_im6,
  output logic signed [OW-1:0] o_im7,
  output logic                 o_ovf
);

  localparam int unsigned W1 = IW + 1;
  localparam int unsigned W2 = IW + 2;
  localparam int unsigned W3 = IW + 4;
  localparam logic signed [W3-1:0] SMAX = W3'((2 ** (OW - 1)) - 1);
  localparam logic signed [W3-1:0] SMIN = W3'(-(2 ** (OW - 1)));

  logic signed [IW-1:0] xr [8];
  logic signed [IW-1:0] xi [8];
  logic signed [W1-1:0] s1r_d [8], s1i_d [8], s1r_q [8], s1i_q [8];
  logic signed [W2-1:0] s2r_d [8], s2i_d [8], s2r_q [8], s2i_q [8];
  logic signed [W3-1:0] s3r [8], s3i [8];
  logic signed [OW-1:0] ore_d [8], oim_d [8], ore_q [8], oim_q [8];
  logic [2:0]           v_q;
  logic                 ovf_d, ovf_q;

  always_comb begin
    xr = '{i_re0, i_re1, i_re2, i_re3, i_re4, i_re5, i_re6, i_re7};
    xi = '{i_im0, i_im1, i_im2, i_im3, i_im4, i_im5, i_im6, i_im7};
  end

  for (genvar p = 0; p < 4; p++) begin : g_s1
    ifft_bfly #(.W(IW), .OWB(W1), .TWW(TWW)) u_bfly (
      .a_re  (xr[ofdm_pkg::BITREV[2*p]]),
      .a_im  (xi[ofdm_pkg::BITREV[2*p]]),
      .b_re  (xr[ofdm_pkg::BITREV[2*p+1]]),
      .b_im  (xi[ofdm_pkg::BITREV[2*p+1]]),
      .sel   (ofdm_pkg::tw_w0),
      .y0_re (s1r_d[2*p]),
      .y0_im (s1i_d[2*p]),
      .y1_re (s1r_d[2*p+1]),
      .y1_im (s1i_d[2*p+1])
    );
  end

  // Two 4-point groups; the odd leg of each group takes the +j twiddle
  for (genvar g = 0; g < 2; g++) begin : g_s2
    for (genvar k = 0; k < 2; k++) begin : g_k
      ifft_bfly #(.W(W1), .OWB(W2), .TWW(TWW)) u_bfly (
        .a_re  (s1r_q[4*g+k]),
        .a_im  (s1i_q[4*g+k]),
        .b_re  (s1r_q[4*g+k+2]),
        .b_im  (s1i_q[4*g+k+2]),
        .sel   ((k == 0) ? ofdm_pkg::tw_w0 : ofdm_pkg::tw_pj),
        .y0_re (s2r_d[4*g+k]),
        .y0_im (s2i_d[4*g+k]),
        .y1_re (s2r_d[4*g+k+2]),
        .y1_im (s2i_d[4*g+k+2])
      );
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_s3
    ifft_bfly #(.W(W2), .OWB(W3), .TWW(TWW)) u_bfly (
      .a_re  (s2r_q[k]),
      .a_im  (s2i_q[k]),
      .b_re  (s2r_q[k+4]),
      .b_im  (s2i_q[k+4]),
      .sel   (stage3_tw(k)),
      .y0_re (s3r[k]),
      .y0_im (s3i[k]),
      .y1_re (s3r[k+4]),
      .y1_im (s3i[k+4])
    );
  end

  function automatic logic signed [OW-1:0] clamp(input logic signed [W3-1:0] x,
                                                  output logic hit);
    hit = 1'b1;
    if (x > SMAX) begin
      clamp = OW'(SMAX);
    end else if (x < SMIN) begin
      clamp = OW'(SMIN);
    end else begin
      clamp = OW'(x);
      hit   = 1'b0;
    end
  endfunction

  always_comb begin
    logic hr, hi;
    ovf_d = 1'b0;
    for (int n = 0; n < 8; n++) begin
      ore_d[n] = clamp(s3r[n], hr);
      oim_d[n] = clamp(s3i[n], hi);
      ovf_d    = ovf_d | hr | hi;
    end
    // Invalid frames still flow through but never raise the flag
    ovf_d = ovf_d & v_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1r_q <= '{default: '0};
      s1i_q <= '{default: '0};
      s2r_q <= '{default: '0};
      s2i_q <= '{default: '0};
      ore_q <= '{default: '0};
      oim_q <= '{default: '0};
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      s1r_q <= s1r_d;
      s1i_q <= s1i_d;
      s2r_q <= s2r_d;
      s2i_q <= s2i_d;
      ore_q <= ore_d;
      oim_q <= oim_d;
      v_q   <= {v_q[1:0], i_valid};
      ovf_q <= ovf_d;
    end
  end

  assign o_valid = v_q[2];
  assign o_ovf   = ovf_q;
  assign o_re0   = ore_q[0];
  assign o_re1   = ore_q[1];
  assign o_re2   = ore_q[2];
  assign o_re3   = ore_q[3];
  assign o_re4   = ore_q[4];
  assign o_re5   = ore_q[5];
  assign o_re6   = ore_q[6];
  assign o_re7   = ore_q[7];
  assign o_im0   = oim_q[0];
  assign o_im1   = oim_q[1];
  assign o_im2   = oim_q[2];
  assign o_im3   = oim_q[3];
  assign o_im4   = oim_q[4];
  assign o_im5   = oim_q[5];
  assign o_im6   = oim_q[6];
  assign o_im7   = oim_q[7];

endmodule

// File: tb/tb_ifft_8.sv
// Directed self-checking bench for ifft_8 with hand-computed frame results.
module tb_ifft_8;

  localparam int unsigned IW = 8;
  localparam int unsigned OW = 11;
  localparam int NV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic i_valid = 1'b0;
  logic signed [IW-1:0] i_re [8];
  logic signed [IW-1:0] i_im [8];
  logic signed [OW-1:0] o_re [8];
  logic signed [OW-1:0] o_im [8];
  logic o_valid, o_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int vin_re [NV][8];
  int vin_im [NV][8];
  int vex_re [NV][8];
  int vex_im [NV][8];
  int vex_ovf [NV];

  always #5 clk = ~clk;

  ifft_8 dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .i_valid (i_valid),
    .i_re0   (i_re[0]), .i_re1 (i_re[1]), .i_re2 (i_re[2]), .i_re3 (i_re[3]),
    .i_re4   (i_re[4]), .i_re5 (i_re[5]), .i_re6 (i_re[6]), .i_re7 (i_re[7]),
    .i_im0   (i_im[0]), .i_im1 (i_im[1]), .i_im2 (i_im[2]), .i_im3 (i_im[3]),
    .i_im4   (i_im[4]), .i_im5 (i_im[5]), .i_im6 (i_im[6]), .i_im7 (i_im[7]),
    .o_valid (o_valid),
    .o_re0   (o_re[0]), .o_re1 (o_re[1]), .o_re2 (o_re[2]), .o_re3 (o_re[3]),
    .o_re4   (o_re[4]), .o_re5 (o_re[5]), .o_re6 (o_re[6]), .o_re7 (o_re[7]),
    .o_im0   (o_im[0]), .o_im1 (o_im[1]), .o_im2 (o_im[2]), .o_im3 (o_im[3]),
    .o_im4   (o_im[4]), .o_im5 (o_im[5]), .o_im6 (o_im[6]), .o_im7 (o_im[7]),
    .o_ovf   (o_ovf)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int v, input bit valid);
    i_valid = valid;
    for (int n = 0; n < 8; n++) begin
      if (v < 0) begin
        i_re[n] = '0;
        i_im[n] = '0;
      end else begin
        i_re[n] = IW'(vin_re[v][n]);
        i_im[n] = IW'(vin_im[v][n]);
      end
    end
  endtask

  task automatic tick(input bit e);
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " o_valid"}, int'(o_valid), 0);
  endtask

  // Vector 3 saturates; only the clamped bin and the flag are pinned down
  task automatic check_frame(input int v, input string tag);
    check({tag, " o_valid"}, int'(o_valid), 1);
    if (v == 3) begin
      check({tag, " re1"}, int'(o_re[1]), 1023);
      check({tag, " ovf"}, int'(o_ovf), 1);
    end else begin
      for (int n = 0; n < 8; n++) begin
        check($sformatf("%s re%0d", tag, n), int'(o_re[n]), vex_re[v][n]);
        check($sformatf("%s im%0d", tag, n), int'(o_im[n]), vex_im[v][n]);
      end
      check({tag, " ovf"}, int'(o_ovf), vex_ovf[v]);
    end
  endtask

  initial begin
    int singles [7] = '{0, 1, 2, 3, 5, 6, 7};
    int s_drv [9] = '{4, 1, 7, 6, 6, 6, -1, -1, -1};
    bit s_en [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    int s_exp [9] = '{-1, -1, 4, 4, 4, 1, 7, 6, -1};

    for (int v = 0; v < NV; v++) begin
      vex_ovf[v] = 0;
      for (int n = 0; n < 8; n++) begin
        vin_re[v][n] = 0; vin_im[v][n] = 0;
        vex_re[v][n] = 0; vex_im[v][n] = 0;
      end
    end
    // 0: DC 4
    vin_re[0][0] = 4;
    for (int n = 0; n < 8; n++) vex_re[0][n] = 4;
    // 1: tone X1 = 16
    vin_re[1][1] = 16;
    vex_re[1] = '{16, 11, 0, -11, -16, -11, 0, 11};
    vex_im[1] = '{0, 11, 16, 11, 0, -11, -16, -11};
    // 2: all -128, x0 lands exactly on the negative limit
    for (int n = 0; n < 8; n++) vin_re[2][n] = -128;
    vex_re[2][0] = -1024;
    // 3: saturating frame
    vin_re[3] = '{127, 127, 0, -127, -128, -127, 0, 127};
    vin_im[3] = '{0, -127, -128, -127, 0, 127, 127, 127};
    vex_ovf[3] = 1;
    // 4: complex DC -8+j8
    vin_re[4][0] = -8;
    vin_im[4][0] = 8;
    for (int n = 0; n < 8; n++) begin
      vex_re[4][n] = -8;
      vex_im[4][n] = 8;
    end
    // 5: X4 = 5-j3 -> alternating sign
    vin_re[5][4] = 5;
    vin_im[5][4] = -3;
    for (int n = 0; n < 8; n++) begin
      vex_re[5][n] = (n % 2 == 0) ? 5 : -5;
      vex_im[5][n] = (n % 2 == 0) ? -3 : 3;
    end
    // 6: X2 = 10 -> 10*j^n
    vin_re[6][2] = 10;
    vex_re[6] = '{10, 0, -10, 0, 10, 0, -10, 0};
    vex_im[6] = '{0, 10, 0, -10, 0, 10, 0, -10};
    // 7: X7 = 16 -> negative-frequency tone, exercises rounding of negative products
    vin_re[7][7] = 16;
    vex_re[7] = '{16, 11, 0, -11, -16, -11, 0, 11};
    vex_im[7] = '{0, -11, -16, -11, 0, 11, 16, 11};

    drive(-1, 1'b0);
    #12;
    check("reset o_valid", int'(o_valid), 0);
    check("reset o_ovf", int'(o_ovf), 0);
    check("reset re0", int'(o_re[0]), 0);
    check("reset im7", int'(o_im[7]), 0);
    rst = 1'b0;

    foreach (singles[i]) begin
      string tag;
      tag = $sformatf("vec%0d", singles[i]);
      drive(singles[i], 1'b1);
      tick(1'b1);
      drive(-1, 1'b0);
      tick(1'b1);
      check_idle({tag, " early"});
      tick(1'b1);
      check_frame(singles[i], tag);
      tick(1'b1);
      check_idle({tag, " after"});
      check({tag, " after ovf"}, int'(o_ovf), 0);
    end

    // Invalid frame carrying saturating data: data flows, flag suppressed
    drive(3, 1'b0);
    tick(1'b1);
    drive(-1, 1'b0);
    tick(1'b1);
    tick(1'b1);
    check_idle("inv");
    check("inv ovf", int'(o_ovf), 0);
    check("inv re1", int'(o_re[1]), 1023);
    tick(1'b1);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("stream e%0d", i + 1);
      drive(s_drv[i], s_drv[i] >= 0);
      tick(s_en[i]);
      if (s_exp[i] < 0) check_idle(tag);
      else check_frame(s_exp[i], tag);
    end

    // Reset between edges with one frame on the outputs and two in flight
    drive(4, 1'b1);
    tick(1'b1);
    drive(1, 1'b1);
    tick(1'b1);
    drive(7, 1'b1);
    tick(1'b1);
    check_frame(4, "pre-rst");
    drive(-1, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("rst o_valid", int'(o_valid), 0);
    check("rst re0", int'(o_re[0]), 0);
    check("rst im0", int'(o_im[0]), 0);
    check("rst re7", int'(o_re[7]), 0);
    check("rst ovf", int'(o_ovf), 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      check_idle($sformatf("post-rst idle%0d", i));
    end
    drive(1, 1'b1);
    tick(1'b1);
    drive(-1, 1'b0);
    tick(1'b1);
    check_idle("post-rst early");
    tick(1'b1);
    check_frame(1, "post-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifft_8.md
# ifft_8

Eight-point, fully parallel, pipelined radix-2 inverse FFT for the OFDM transmitter path. It is the counterpart of the receiver-side `fft_8` and uses the same parallel port style and signed fixed-point input width. It accepts one frame of eight frequency-domain QAM points per enabled cycle and emits eight time-domain samples three enabled cycles later. Output is unscaled (N·x[n]) and saturated to the output width, with a per-frame overflow flag.

## Interface
Parameters:
- IW, 8, input component width, signed two's complement
- OW, 11, output component width (IW + 3 stages of growth)
- TWW, 8, twiddle magnitude width; √2/2 constant = 91 (Q0.7)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global clock enable; when 0, every register holds
- i_valid  in  1  input frame valid, sampled when en=1
- i_re0..i_re7  in  IW each  real part of X[0..7]
- i_im0..i_im7  in  IW each  imaginary part of X[0..7]
- o_valid  out  1  output frame valid
- o_re0..o_re7  out  OW each  real part of x[0..7]
- o_im0..o_im7  out  OW each  imaginary part of x[0..7]
- o_ovf  out  1  at least one output component saturated in this frame

## Operation
- Function: x[n] = Σk X[k]·e^{+j2πkn/8}. No 1/8 scaling.
- Structure: decimation-in-time. Inputs are bit-reversed internally (0,4,2,6,1,5,3,7).
- Stage 1: W⁰ butterflies on pairs (0,4),(2,6),(1,5),(3,7). Width grows to IW+1.
- Stage 2: twiddles W⁰ and +j. The +j multiply is exact: (a+jb)·j = −b+ja. Width grows to IW+2.
- Stage 3: twiddles W⁰, (1+j)/√2, +j, (−1+j)/√2.
  - Diagonal twiddles: compute (a∓b) and (a±b) exactly, multiply by 91, add 64, arithmetic-shift right 7 (round half up).
  - Internal width is IW+4. Do not truncate before saturation.
- Saturation: each stage-3 result is clamped to [−1024, +1023]. o_ovf = OR of the 16 clamp events for that frame.
- Each stage is one register bank. i_valid propagates alongside the data as a 3-deep valid shift register.
- Frames with i_valid=0 still flow through the datapath. Their o_valid is 0 and their o_ovf is forced to 0.

## Timing
- Latency: 3 enabled cycles. A frame sampled at en-qualified edge t appears on the outputs after edge t+3.
- Throughput: one frame per enabled cycle. No backpressure.
- en=0: all pipeline registers, including valid and o_ovf, hold their values. Outputs stay stable.
- Reset: all outputs are 0 and all valid bits are 0. Reset takes effect immediately, independent of clk and en.
- Reset mid-operation: in-flight frames are discarded. The first o_valid after release follows the first valid frame sampled after release, 3 enabled cycles later.
- Back-to-back valid frames produce back-to-back o_valid with no bubbles.

## Structure
- Shared package `ofdm_pkg`:
  - IW, OW, TWW
  - twiddle constant 91, rounding constant 64
  - saturation limits −1024 / +1023
  - bit-reverse index constants
- Sub-module `ifft_bfly`: a complex radix-2 butterfly with a 2-bit twiddle select (W⁰, +j, (1+j)/√2, (−1+j)/√2). It is combinational; ifft_8 instantiates it 12 times and owns all stage registers.

## Test plan
- DC: X0=4+j0, others 0, i_valid=1 for one cycle → after 3 cycles o_valid=1 for exactly one cycle, all x[n]=4+j0, o_ovf=0.
- Single tone: X1=16, others 0 → x0=16, x1=11+j11, x2=j16, x3=−11+j11, x4=−16, x5=−11−j11, x6=−j16, x7=11−j11.
- Boundary: all X[k]=−128+j0 → x0=−1024 (no clamp), x1..x7=0, o_ovf=0.
- Saturation:
  - Stimulus: X=(127,0),(127,−127),(0,−128),(−127,−127),(−128,0),(−127,127),(0,127),(127,127).
  - Response: o_re1=1023, o_ovf=1.
- Stall and stream:
  - Stimulus: 4 consecutive valid frames, with en=0 held for 2 cycles mid-stream.
  - Response: outputs hold during the stall, and all 4 frames emerge in order with correct values.
- Reset: assert rst asynchronously between edges with 2 frames in flight → o_valid and all outputs drop to 0 immediately, and no stale frame appears after release.
